instr_issue: RTL and testbench

Instruction issue stage that sits directly upstream of the `Pipeline` core and drives its 32-bit `InstrIn` port. It buffers instructions from a loader in a small FIFO and presents at most one instruction per cycle. The core has no forwarding, so the block holds back any instruction whose source register is still being written by a recently issued instruction, and issues a bubble (32'h0000_0000) instead.

---
 rtl/instr_pkg.sv | 62 ++++++
 rtl/instr_fifo.sv | 70 +++++++
 rtl/instr_issue.sv | 122 ++++++++++++
 tb/tb_instr_issue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// ============================================================================
// Module : instr_pkg
// Brief  : Instruction encoding shared by the issue stage and the core decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_pkg;

    localparam logic [5:0] OP_MOV  = 6'd0;
    localparam logic [5:0] OP_NOT  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;
    localparam logic [5:0] OP_NOR  = 6'd4;
    localparam logic [5:0] OP_NAND = 6'd5;
    localparam logic [5:0] OP_SUB  = 6'd6;
    localparam logic [5:0] OP_SLT  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd11;
    localparam logic [5:0] OP_SUBI = 6'd14;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    // Every defined opcode reads rs; undefined ones are treated as reading it too.
    function automatic logic uses_rs(input logic [5:0] op);
        logic w_use;
        case (op)
            OP_MOV, OP_NOT, OP_AND, OP_ADD, OP_NOR,
            OP_NAND, OP_SUB, OP_SLT, OP_ADDI, OP_SUBI: w_use = 1'b1;
            default:                                   w_use = 1'b1;
        endcase
        return w_use;
    endfunction

    // Single-source and immediate forms reuse the rt bits as data.
    function automatic logic uses_rt(input logic [5:0] op);
        logic w_use;
        case (op)
            OP_MOV, OP_NOT, OP_ADDI, OP_SUBI: w_use = 1'b0;
            default:                          w_use = 1'b1;
        endcase
        return w_use;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module : instr_fifo
// Brief  : Synchronous FIFO with flush, occupancy count and combinational head.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_issue.sv
// ============================================================================
// Module : instr_issue
// Brief  : Buffers loader instructions and issues one per cycle, inserting
//          bubbles while a source register is still in flight (no forwarding).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_issue
    import instr_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int HAZ_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [31:0]             in_instr,
    output logic                    in_ready,
    output logic [31:0]             issue_instr,
    output logic                    issue_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             stall_cnt
);

    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_raw;
    logic        w_hazard;
    logic [5:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;

    sb_entry_t   r_sb [HAZ_DEPTH];
    logic [31:0] r_issue_instr;
    logic        r_issue_valid;
    logic [15:0] r_stall_cnt;

    assign in_ready = !w_full && !rst && !flush;
    assign w_push   = in_valid && in_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (in_instr),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_op = w_head[OP_MSB:OP_LSB];
    assign w_rd = w_head[RD_MSB:RD_LSB];
    assign w_rs = w_head[RS_MSB:RS_LSB];
    assign w_rt = w_head[RT_MSB:RT_LSB];

    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_sb[i].valid &&
                ((uses_rs(w_op) && (r_sb[i].rd == w_rs)) ||
                 (uses_rt(w_op) && (r_sb[i].rd == w_rt)))) begin
                w_raw = 1'b1;
            end
        end
    end

    assign w_hazard = !w_empty && w_raw;
    assign w_pop    = !w_empty && !w_hazard && !rst && !flush;

    // Slot 0 holds the most recent issue slot; a bubble shifts in as invalid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= '{valid: w_pop, rd: w_rd};
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_instr <= BUBBLE;
            r_issue_valid <= 1'b0;
            r_stall_cnt   <= 16'h0000;
        end else if (flush) begin
            r_issue_instr <= BUBBLE;
            r_issue_valid <= 1'b0;
        end else if (w_pop) begin
            r_issue_instr <= w_head;
            r_issue_valid <= 1'b1;
        end else begin
            r_issue_instr <= BUBBLE;
            r_issue_valid <= 1'b0;
            if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign issue_instr = r_issue_instr;
    assign issue_valid = r_issue_valid;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_issue.sv
// ============================================================================
// Module : tb_instr_issue
// Brief  : Directed vector table plus randomized traffic for instr_issue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_issue;

    localparam int DEPTH     = 4;
    localparam int HAZ_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] stall_cnt;

    instr_issue #(
        .DEPTH     (DEPTH),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .issue_instr (issue_instr),
        .issue_valid (issue_valid),
        .fifo_count  (fifo_count),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of buffered words and the destinations of the
    // last HAZ_DEPTH issue slots (-1 marks a bubble slot).
    logic [31:0] m_q [$];
    int          m_hist [HAZ_DEPTH];
    int          m_stall = 0;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;

    function automatic bit reads_rt(input int op);
        return !(op == 0 || op == 1 || op == 11 || op == 14);
    endfunction

    task automatic model_step(input logic r, input logic f, input logic v, input logic [31:0] w);
        bit          rdy;
        bit          haz;
        int          newrd;
        int          op;
        int          rs;
        int          rt;
        logic [31:0] head;
        rdy   = (m_q.size() < DEPTH) && !r && !f;
        newrd = -1;
        haz   = 0;
        if (r || f) begin
            m_q.delete();
            for (int i = 0; i < HAZ_DEPTH; i++) m_hist[i] = -1;
            m_instr = 32'h0;
            m_valid = 1'b0;
            if (r) m_stall = 0;
        end else begin
            m_instr = 32'h0;
            m_valid = 1'b0;
            if (m_q.size() != 0) begin
                head = m_q[0];
                op   = int'(head[31:26]);
                rs   = int'(head[20:16]);
                rt   = int'(head[15:11]);
                for (int i = 0; i < HAZ_DEPTH; i++) begin
                    if (m_hist[i] >= 0 && (m_hist[i] == rs || (reads_rt(op) && m_hist[i] == rt)))
                        haz = 1;
                end
                if (haz) begin
                    if (m_stall < 65535) m_stall++;
                end else begin
                    m_instr = head;
                    m_valid = 1'b1;
                    newrd   = int'(head[25:21]);
                    void'(m_q.pop_front());
                end
            end
            for (int i = HAZ_DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = newrd;
            if (v && rdy) m_q.push_back(w);
        end
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic v, input logic [31:0] w,
                        output logic rdy_s);
        @(negedge clk);
        rst      = r;
        flush    = f;
        in_valid = v;
        in_instr = w;
        #1;
        rdy_s = in_ready;
        @(posedge clk);
        model_step(r, f, v, w);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        f;
        logic        v;
        logic [31:0] w;
        logic        rdy;
        logic [31:0] ins;
        logic        vld;
        int          cnt;
        int          stl;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic v, logic [31:0] w, logic rdy,
                                logic [31:0] ins, logic vld, int cnt, int stl);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.w = w; t.rdy = rdy;
        t.ins = ins; t.vld = vld; t.cnt = cnt; t.stl = stl;
        return t;
    endfunction

    localparam logic [31:0] A  = 32'h0C611000;  // add r3=r1+r2
    localparam logic [31:0] B  = 32'h08A11000;  // and r5=r1&r2
    localparam logic [31:0] C  = 32'h07C30000;  // not r30=~r3
    localparam logic [31:0] D  = 32'h2C811800;  // addi r4=r1+0x1800
    localparam logic [31:0] E1 = 32'h07BE0000;  // not r29=~r30
    localparam logic [31:0] E2 = 32'h0CC11000;  // add r6=r1+r2
    localparam logic [31:0] E3 = 32'h08E11000;  // and r7=r1&r2
    localparam logic [31:0] E4 = 32'h2D010005;  // addi r8=r1+5
    localparam logic [31:0] E5 = 32'h19211000;  // sub r9=r1-r2

    vec_t        tab [$];
    logic [5:0]  ops [13] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                              6'd11, 6'd14, 6'd9, 6'd20, 6'd63};

    initial begin
        logic        rs;
        logic        er;
        logic        r;
        logic        f;
        logic        v;
        logic [31:0] w;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
        for (int i = 0; i < HAZ_DEPTH; i++) m_hist[i] = -1;

        //              r  f  v  word rdy  issue   vld cnt stall
        tab.push_back(mk(1, 0, 1, A,  0, 32'h0, 0, 0, 0));   // reset held
        tab.push_back(mk(1, 0, 1, A,  0, 32'h0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 0));   // independent pair
        tab.push_back(mk(0, 0, 1, B,  1, A,     1, 1, 0));
        tab.push_back(mk(0, 0, 0, 0,  1, B,     1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 0));   // RAW hazard
        tab.push_back(mk(0, 0, 1, C,  1, A,     1, 1, 0));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 1, 1));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 1, 2));
        tab.push_back(mk(0, 0, 0, 0,  1, C,     1, 0, 2));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 2));   // immediate ignores rt
        tab.push_back(mk(0, 0, 1, D,  1, A,     1, 1, 2));
        tab.push_back(mk(0, 0, 0, 0,  1, D,     1, 0, 2));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 0, 2));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 2));   // fill under stall, wrap
        tab.push_back(mk(0, 0, 1, C,  1, A,     1, 1, 2));
        tab.push_back(mk(0, 0, 1, E1, 1, 32'h0, 0, 2, 3));
        tab.push_back(mk(0, 0, 1, E2, 1, 32'h0, 0, 3, 4));
        tab.push_back(mk(0, 0, 1, E3, 1, C,     1, 3, 4));
        tab.push_back(mk(0, 0, 1, E4, 1, 32'h0, 0, 4, 5));
        tab.push_back(mk(0, 0, 1, E5, 0, 32'h0, 0, 4, 6));
        tab.push_back(mk(0, 0, 1, E5, 0, E1,    1, 3, 6));
        tab.push_back(mk(0, 0, 1, E5, 1, E2,    1, 3, 6));
        tab.push_back(mk(0, 0, 0, 0,  1, E3,    1, 2, 6));
        tab.push_back(mk(0, 0, 0, 0,  1, E4,    1, 1, 6));
        tab.push_back(mk(0, 0, 0, 0,  1, E5,    1, 0, 6));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 0, 6));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 6));   // flush mid-stall
        tab.push_back(mk(0, 0, 1, C,  1, A,     1, 1, 6));
        tab.push_back(mk(0, 0, 1, E2, 1, 32'h0, 0, 2, 7));
        tab.push_back(mk(0, 0, 1, E3, 1, 32'h0, 0, 3, 8));
        tab.push_back(mk(0, 1, 1, E4, 0, 32'h0, 0, 0, 8));
        tab.push_back(mk(0, 0, 1, C,  1, 32'h0, 0, 1, 8));
        tab.push_back(mk(0, 0, 0, 0,  1, C,     1, 0, 8));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 0, 8));
        tab.push_back(mk(0, 0, 1, A,  1, 32'h0, 0, 1, 8));   // reset mid-stall
        tab.push_back(mk(0, 0, 1, C,  1, A,     1, 1, 8));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 1, 9));
        tab.push_back(mk(1, 0, 1, E2, 0, 32'h0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0,  1, 32'h0, 0, 0, 0));

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].r, tab[i].f, tab[i].v, tab[i].w, rs);
            chk("tab_in_ready",    i, 32'(rs),          32'(tab[i].rdy));
            chk("tab_issue_instr", i, issue_instr,      tab[i].ins);
            chk("tab_issue_valid", i, 32'(issue_valid), 32'(tab[i].vld));
            chk("tab_fifo_count",  i, 32'(fifo_count),  32'(tab[i].cnt));
            chk("tab_stall_cnt",   i, 32'(stall_cnt),   32'(tab[i].stl));
        end

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) == 0);
            f = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            w = {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
            er = (m_q.size() < DEPTH) && !r && !f;
            step(r, f, v, w, rs);
            chk("rnd_in_ready",    i, 32'(rs),          32'(er));
            chk("rnd_issue_instr", i, issue_instr,      m_instr);
            chk("rnd_issue_valid", i, 32'(issue_valid), 32'(m_valid));
            chk("rnd_fifo_count",  i, 32'(fifo_count),  32'(m_q.size()));
            chk("rnd_stall_cnt",   i, 32'(stall_cnt),   32'(m_stall));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
